// File: rtl/decoder_pkg.sv
// Shared types, mode constants and the one-hot helper for decoder_scan_n.
// Optional build macro: DECODER_SCAN_BLANK_EN (scan blanking cycle, see top).
package decoder_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // Values of the mode input.
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest index the helper supports; callers truncate to their own width.
  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

  // One-hot of idx over MAX_OUT_W bits; bits at or above 2**width are forced to zero.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx,
                                                  input int unsigned width);
    logic [MAX_OUT_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
      if ((i < (32'd1 << width)) && (idx == MAX_SEL_W'(i))) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Purely combinational SEL_W-to-2**SEL_W one-hot decoder.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 3
) (
  input  logic [SEL_W-1:0]      in,
  output logic [(1<<SEL_W)-1:0] out
);

  localparam int unsigned OUT_W = 1 << SEL_W;

  // Decode through the shared helper and keep only the low OUT_W bits.
  always_comb begin
    out = OUT_W'(onehot(MAX_SEL_W'(in), SEL_W));
  end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2**N one-hot decoder with direct (handshake) and auto-scan modes.
// Optional build macro: DECODER_SCAN_BLANK_EN inserts one all-zero cycle before each
// new scan position (period dwell+2); without it the scan period is dwell+1.
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    sel_valid,
  input  logic [SEL_W-1:0]        sel,
  output logic                    sel_ready,
  input  logic [DWELL_W-1:0]      dwell,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    wrap
);

  localparam int unsigned OUT_W = 1 << SEL_W;

  state_e               state_q, state_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;
`ifdef DECODER_SCAN_BLANK_EN
  logic                 blank_q, blank_d;
`endif

  logic [SEL_W-1:0]     next_sel;
  logic                 dwell_done;
  logic                 last_pos;
  logic [SEL_W-1:0]     dec_idx;
  logic [OUT_W-1:0]     dec_out;

  // Scan bookkeeping shared by the index mux and next-state logic.
  always_comb begin
    next_sel   = cur_sel_q + SEL_W'(1);
    dwell_done = (cnt_q == dwell);
    last_pos   = &cur_sel_q;
  end

  // Select which index the decoder should present as the candidate next output.
  always_comb begin
    dec_idx = cur_sel_q;
    if ((state_q == DIRECT) && (mode == MODE_DIRECT)) begin
      dec_idx = sel;
    end
`ifndef DECODER_SCAN_BLANK_EN
    if ((state_q == SCAN) && (mode == MODE_SCAN) && dwell_done) begin
      dec_idx = next_sel;
    end
`endif
  end

  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_onehot_dec (
    .in  (dec_idx),
    .out (dec_out)
  );

  // Next-state and next-output logic for the IDLE/DIRECT/SCAN controller.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    cur_sel_d = cur_sel_q;
    cnt_d     = cnt_q;
    wrap_d    = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
    blank_d   = 1'b0;
`endif

    if (!en) begin
      // Disable: blank outputs, keep the index so a later scan resumes in place.
      state_d = IDLE;
      out_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (mode == MODE_SCAN) begin
            state_d = SCAN;
            out_d   = dec_out;
          end else begin
            state_d = DIRECT;
            out_d   = '0;
          end
        end

        DIRECT: begin
          if (mode == MODE_SCAN) begin
            // A handshake in the switching cycle is intentionally dropped.
            state_d = SCAN;
            out_d   = dec_out;
            cnt_d   = '0;
          end else if (sel_valid) begin
            out_d     = dec_out;
            cur_sel_d = sel;
          end
        end

        SCAN: begin
          if (mode == MODE_DIRECT) begin
            state_d = DIRECT;
            cnt_d   = '0;
          end else begin
`ifdef DECODER_SCAN_BLANK_EN
            if (blank_q) begin
              out_d = dec_out;
              cnt_d = '0;
            end else if (dwell_done) begin
              cnt_d     = '0;
              cur_sel_d = next_sel;
              out_d     = '0;
              wrap_d    = last_pos;
              blank_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + DWELL_W'(1);
            end
`else
            if (dwell_done) begin
              cnt_d     = '0;
              cur_sel_d = next_sel;
              out_d     = dec_out;
              wrap_d    = last_pos;
            end else begin
              // Free-running wrap lets a lowered dwell still end the position.
              cnt_d = cnt_q + DWELL_W'(1);
            end
`endif
          end
        end

        default: begin
          state_d = IDLE;
          out_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_q     <= '0;
      cur_sel_q <= '0;
      cnt_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      cur_sel_q <= cur_sel_d;
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
    end
  end

`ifdef DECODER_SCAN_BLANK_EN
  // Blanking-phase flag: high for the single all-zero cycle between positions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end
`endif

  // Ready is combinational so a DIRECT-state handshake completes in one cycle.
  always_comb begin
    sel_ready = (state_q == DIRECT) && en;
    out       = out_q;
    cur_sel   = cur_sel_q;
    wrap      = wrap_q;
  end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed scoreboard bench for decoder_scan_n (default SEL_W=3, DWELL_W=8).
module tb_decoder_scan_n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       sel_valid;
  logic [2:0] sel;
  logic       sel_ready;
  logic [7:0] dwell;
  logic [7:0] out;
  logic [2:0] cur_sel;
  logic       wrap;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] c;
    logic       w;
    logic       r;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_pos = 0;

  decoder_scan_n #(
    .SEL_W   (3),
    .DWELL_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sel_valid (sel_valid),
    .sel       (sel),
    .sel_ready (sel_ready),
    .dwell     (dwell),
    .out       (out),
    .cur_sel   (cur_sel),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] o, input logic [2:0] c, input logic w,
                          input logic r);
    exp_t e;
    e.o = o;
    e.c = c;
    e.w = w;
    e.r = r;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s scoreboard empty got=%0d want=1", tag, sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      assert (out === e.o) else begin
        bad++;
        $error("FAIL %s out got=%h want=%h", tag, out, e.o);
      end
      total++;
      assert (cur_sel === e.c) else begin
        bad++;
        $error("FAIL %s cur_sel got=%0d want=%0d", tag, cur_sel, e.c);
      end
      total++;
      assert (wrap === e.w) else begin
        bad++;
        $error("FAIL %s wrap got=%b want=%b", tag, wrap, e.w);
      end
      total++;
      assert (sel_ready === e.r) else begin
        bad++;
        $error("FAIL %s sel_ready got=%b want=%b", tag, sel_ready, e.r);
      end
    end
  endtask

  // Push the expectation for the next edge, clock once, then compare.
  task automatic cyc(input string tag, input logic [7:0] o, input logic [2:0] c,
                     input logic w, input logic r);
    push_exp(o, c, w, r);
    step();
    check(tag);
  endtask

  // Walk npos scan positions from exp_pos; dwell takes the new value once the
  // first position is on the outputs so the preceding advance is not disturbed.
  task automatic scan_walk(input int dw, input int npos, input bit entry);
    for (int i = 0; i < npos; i++) begin
      int pos;
      pos = exp_pos;
      for (int k = 0; k <= dw; k++) begin
        logic       w;
        logic [7:0] oh;
        oh = 8'd1 << pos;
`ifdef DECODER_SCAN_BLANK_EN
        w = 1'b0;
`else
        w = (k == 0) && (pos == 0) && !(entry && (i == 0));
`endif
        cyc("scan", oh, 3'(pos), w, 1'b0);
        if ((i == 0) && (k == 0)) dwell = 8'(dw);
      end
      exp_pos = (pos + 1) % 8;
`ifdef DECODER_SCAN_BLANK_EN
      cyc("blank", 8'h00, 3'(exp_pos), (exp_pos == 0), 1'b0);
`endif
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    mode      = 1'b0;
    sel_valid = 1'b0;
    sel       = 3'd0;
    dwell     = 8'd2;
    step();
    step();
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    check("reset");

    // Direct mode: entry shows zero until the first handshake.
    rst_n = 1'b1;
    en    = 1'b1;
    mode  = 1'b0;
    cyc("direct_entry", 8'h00, 3'd0, 1'b0, 1'b1);
    sel_valid = 1'b1;
    sel       = 3'd5;
    cyc("direct_sel5", 8'h20, 3'd5, 1'b0, 1'b1);
    sel_valid = 1'b0;
    sel       = 3'd2;
    cyc("direct_hold", 8'h20, 3'd5, 1'b0, 1'b1);
    cyc("direct_hold2", 8'h20, 3'd5, 1'b0, 1'b1);
    sel_valid = 1'b1;
    sel       = 3'd7;
    cyc("direct_sel7", 8'h80, 3'd7, 1'b0, 1'b1);
    sel       = 3'd0;
    cyc("direct_sel0", 8'h01, 3'd0, 1'b0, 1'b1);
    sel_valid = 1'b0;

    // Scan with dwell=2 for two full rounds, then dwell=0 for two rounds.
    mode    = 1'b1;
    exp_pos = 0;
    scan_walk(2, 16, 1'b1);
    scan_walk(0, 16, 1'b0);

    // Walk to position 3, then switch to direct mid-position.
    scan_walk(2, 3, 1'b0);
    cyc("scan_pos3", 8'h08, 3'd3, 1'b0, 1'b0);
    mode = 1'b0;
    cyc("to_direct", 8'h08, 3'd3, 1'b0, 1'b1);
    cyc("direct_keep", 8'h08, 3'd3, 1'b0, 1'b1);
    sel_valid = 1'b1;
    sel       = 3'd6;
    cyc("direct_sel6", 8'h40, 3'd6, 1'b0, 1'b1);

    // Back to scan with a handshake offered in the switching cycle: it is dropped.
    sel  = 3'd1;
    mode = 1'b1;
    exp_pos = 6;
    scan_walk(2, 3, 1'b1);
    sel_valid = 1'b0;
    scan_walk(2, 3, 1'b0);

    // Drop enable at position 4, then resume with a full dwell at 4.
    cyc("scan_pos4", 8'h10, 3'd4, 1'b0, 1'b0);
    en = 1'b0;
    cyc("en_low", 8'h00, 3'd4, 1'b0, 1'b0);
    cyc("en_low_idle", 8'h00, 3'd4, 1'b0, 1'b0);
    en = 1'b1;
    exp_pos = 4;
    scan_walk(2, 2, 1'b1);

    // Asynchronous reset between edges, mid-dwell.
    cyc("scan_pos6", 8'h40, 3'd6, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    check("async_reset");
    cyc("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    exp_pos = 0;
    scan_walk(2, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
